// File: rtl/pipelined_seg_adder.sv
// Segmented pipelined adder: one SEG_WIDTH-bit segment per stage, optional
// sign-extension estimate for the low APPROX_SEGS segments, valid/ready on both sides.
module pipelined_seg_adder #(
  parameter int WIDTH       = 12,
  parameter int SEG_WIDTH   = 4,
  parameter int APPROX_SEGS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             approx,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  localparam int NSEG = WIDTH / SEG_WIDTH;
  localparam int L    = APPROX_SEGS * SEG_WIDTH;
  localparam int BW   = SEG_WIDTH * NSEG * (NSEG - 1) / 2;

  // Stage j keeps NSEG-1-j unconsumed b segments; fields are packed back to back.
  function automatic int boff(int j);
    return SEG_WIDTH * (j * (NSEG - 1) - (j * (j - 1)) / 2);
  endfunction

  logic                       stall;
  logic [NSEG-1:0]            vld_d, vld_q, c_d, c_q;
  logic [NSEG-2:0]            ap_d, ap_q;
  logic [NSEG-1:0][WIDTH-1:0] acc_d, acc_q;
  logic [BW-1:0]              brem_d, brem_q;

  assign stall    = vld_q[NSEG-1] & ~out_ready;
  assign in_ready = ~stall;

  // acc rotates right one segment per stage: unconsumed a on the low side,
  // finished sum segments entering from the top, so after NSEG stages acc == s.
  for (genvar i = 0; i < NSEG; i++) begin : g_st
    localparam int REM = WIDTH - i * SEG_WIDTH;
    logic                 v_in, ap_in, c_in, sgn, c_out;
    logic [WIDTH-1:0]     acc_in;
    logic [REM-1:0]       b_in;
    logic [SEG_WIDTH:0]   seg;
    logic [SEG_WIDTH-1:0] seg_s;

    if (i == 0) begin : g_head
      assign v_in   = in_valid;
      assign ap_in  = approx;
      assign c_in   = cin;
      assign acc_in = a;
      assign b_in   = b;
    end else begin : g_link
      localparam int PO = boff(i - 1);
      assign v_in   = vld_q[i-1];
      assign ap_in  = ap_q[i-1];
      assign c_in   = c_q[i-1];
      assign acc_in = acc_q[i-1];
      assign b_in   = brem_q[PO +: REM];
    end

    if (i < APPROX_SEGS) begin : g_sgn
      assign sgn = acc_in[L-1-i*SEG_WIDTH];
    end else begin : g_nosgn
      assign sgn = 1'b0;
    end

    always_comb begin
      seg   = {1'b0, acc_in[SEG_WIDTH-1:0]} + {1'b0, b_in[SEG_WIDTH-1:0]}
            + {{SEG_WIDTH{1'b0}}, c_in};
      seg_s = seg[SEG_WIDTH-1:0];
      c_out = seg[SEG_WIDTH];
      if (ap_in && (i < APPROX_SEGS)) begin
        seg_s = {SEG_WIDTH{sgn}};
        c_out = sgn;
      end
    end

    assign vld_d[i] = v_in;
    assign c_d[i]   = c_out;
    assign acc_d[i] = {seg_s, acc_in[WIDTH-1:SEG_WIDTH]};
    if (i < NSEG - 1) begin : g_fwd
      assign ap_d[i]                            = ap_in;
      assign brem_d[boff(i) +: REM - SEG_WIDTH] = b_in[REM-1:SEG_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      c_q    <= '0;
      ap_q   <= '0;
      acc_q  <= '0;
      brem_q <= '0;
    end else if (!stall) begin
      vld_q  <= vld_d;
      c_q    <= c_d;
      ap_q   <= ap_d;
      acc_q  <= acc_d;
      brem_q <= brem_d;
    end
  end

  assign out_valid = vld_q[NSEG-1];
  assign s         = acc_q[NSEG-1];
  assign cout      = c_q[NSEG-1];
endmodule

// File: tb/tb_pipelined_seg_adder.sv
// Bench for pipelined_seg_adder: default instance plus two parameter variants,
// scoreboard queues fed at accept time and drained at output transfer.
module tb_pipelined_seg_adder;
  localparam int W = 12, SW = 4, K = 1, NS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_valid, in_ready, approx, cin, out_valid, out_ready, cout;
  logic [W-1:0] a, b, s;

  logic x_iv, x_ir, x_ap, x_ci, x_ov, x_or, x_co;
  logic [15:0] x_a, x_b, x_s;
  logic y_iv, y_ir, y_ap, y_ci, y_ov, y_or, y_co;
  logic [7:0] y_a, y_b, y_s;

  int errors = 0, checks = 0;
  logic [31:0] q_main[$], q_x[$], q_y[$];

  pipelined_seg_adder #(.WIDTH(W), .SEG_WIDTH(SW), .APPROX_SEGS(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .approx(approx),
    .cin(cin), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout));

  pipelined_seg_adder #(.WIDTH(16), .SEG_WIDTH(4), .APPROX_SEGS(2)) dut_x (
    .clk(clk), .rst(rst), .in_valid(x_iv), .in_ready(x_ir), .approx(x_ap),
    .cin(x_ci), .a(x_a), .b(x_b), .out_valid(x_ov), .out_ready(x_or), .s(x_s), .cout(x_co));

  pipelined_seg_adder #(.WIDTH(8), .SEG_WIDTH(2), .APPROX_SEGS(0)) dut_y (
    .clk(clk), .rst(rst), .in_valid(y_iv), .in_ready(y_ir), .approx(y_ap),
    .cin(y_ci), .a(y_a), .b(y_b), .out_valid(y_ov), .out_ready(y_or), .s(y_s), .cout(y_co));

  // Whole-word reference: returns {cout, s} in bits [w:0].
  function automatic logic [31:0] ref_add(int w, int sw, int k, logic [31:0] ta,
                                          logic [31:0] tb, logic ci, logic ap);
    logic [31:0] r, sg;
    int l;
    if (ap && k > 0) begin
      l  = k * sw;
      sg = (ta >> (l - 1)) & 32'd1;
      r  = ((ta >> l) + (tb >> l) + sg) << l;
      if (sg != 0) r = r | ((32'd1 << l) - 32'd1);
    end else begin
      r = ta + tb + {31'd0, ci};
    end
    return r & ((32'd1 << (w + 1)) - 32'd1);
  endfunction

  task automatic drive(input logic v, input logic ap, input logic [W-1:0] ta,
                       input logic [W-1:0] tb, input logic c);
    in_valid = v; approx = ap; a = ta; b = tb; cin = c;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    x_iv = 0; x_ap = 0; x_ci = 0; x_a = '0; x_b = '0; x_or = 1;
    y_iv = 0; y_ap = 0; y_ci = 0; y_a = '0; y_b = '0; y_or = 1;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (s !== '0) begin errors++; $display("FAIL reset_s got %h want 000", s); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (x_ov !== 1'b0 || y_ov !== 1'b0) begin errors++; $display("FAIL reset_sweep_valid got %b%b want 00", x_ov, y_ov); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_exact();
    drive(1'b1, 1'b0, 12'h7FF, 12'h001, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 12'hFFF, 12'h001, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL exact_lat1 got %b want 0", out_valid); end
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL exact_lat2 got %b want 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || s !== 12'h800 || cout !== 1'b0) begin
      errors++; $display("FAIL exact_ripple got v=%b s=%h c=%b want v=1 s=800 c=0", out_valid, s, cout);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || s !== 12'h000 || cout !== 1'b1) begin
      errors++; $display("FAIL exact_wrap got v=%b s=%h c=%b want v=1 s=000 c=1", out_valid, s, cout);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL exact_tail got %b want 0", out_valid); end
  endtask

  task automatic test_approx();
    logic [W-1:0] ta[4] = '{12'h0A8, 12'h0A0, 12'h0A8, 12'h0A0};
    logic [12:0]  ex[4] = '{13'h00CF, 13'h00B0, 13'h00C7, 13'h00BF};
    logic         tc[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic         tap[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] ev;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, tap[i], ta[i], 12'h01F, tc[i]);
      #1;
      if (in_valid && in_ready) q_main.push_back(32'(ex[i]));
      if (out_valid && out_ready) begin
        checks++; ev = q_main.pop_front();
        if (32'({cout, s}) !== ev) begin errors++; $display("FAIL approx got %h want %h", {cout, s}, ev); end
      end
      @(negedge clk);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    for (int g = 0; g < 20 && q_main.size() > 0; g++) begin
      #1;
      if (out_valid && out_ready) begin
        checks++; ev = q_main.pop_front();
        if (32'({cout, s}) !== ev) begin errors++; $display("FAIL approx got %h want %h", {cout, s}, ev); end
      end
      @(negedge clk);
    end
    checks++; if (q_main.size() != 0) begin errors++; $display("FAIL approx_drain left %0d want 0", q_main.size()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ev;
    for (int j = 0; j < 100 + NS + 2; j++) begin
      if (j < 100) drive(1'b1, 1'($urandom_range(0, 1)), W'($urandom()), W'($urandom()), 1'($urandom_range(0, 1)));
      else drive(1'b0, 1'b0, '0, '0, 1'b0);
      #1;
      if (in_valid && in_ready) q_main.push_back(ref_add(W, SW, K, 32'(a), 32'(b), cin, approx));
      checks++;
      if (out_valid !== 1'(j >= NS && j < NS + 100)) begin
        errors++; $display("FAIL stream_valid cycle %0d got %b want %b", j, out_valid, (j >= NS && j < NS + 100));
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q_main.size() == 0) begin errors++; $display("FAIL stream extra result got %h want none", {cout, s}); end
        else begin
          ev = q_main.pop_front();
          if (32'({cout, s}) !== ev) begin errors++; $display("FAIL stream got %h want %h", {cout, s}, ev); end
        end
      end
      @(negedge clk);
    end
    checks++; if (q_main.size() != 0) begin errors++; $display("FAIL stream_drain left %0d want 0", q_main.size()); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ev;
    logic [W-1:0] hs;
    logic hc;
    for (int j = 0; j < NS + 2; j++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), W'($urandom()), W'($urandom()), 1'($urandom_range(0, 1)));
      #1;
      if (in_valid && in_ready) q_main.push_back(ref_add(W, SW, K, 32'(a), 32'(b), cin, approx));
      if (out_valid && out_ready) begin
        checks++; ev = q_main.pop_front();
        if (32'({cout, s}) !== ev) begin errors++; $display("FAIL bp_fill got %h want %h", {cout, s}, ev); end
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 12'h5C3, 12'h2A7, 1'b1);
    hs = 'x; hc = 1'bx;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c == 0) begin hs = s; hc = cout; end
      if (in_valid && in_ready) q_main.push_back(ref_add(W, SW, K, 32'(a), 32'(b), cin, approx));
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      checks++;
      if (out_valid !== 1'b1 || s !== hs || cout !== hc) begin
        errors++; $display("FAIL bp_hold got v=%b s=%h c=%b want v=1 s=%h c=%b", out_valid, s, cout, hs, hc);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int g = 0; g < 20 && (g == 0 || q_main.size() > 0); g++) begin
      #1;
      if (in_valid && in_ready) q_main.push_back(ref_add(W, SW, K, 32'(a), 32'(b), cin, approx));
      if (out_valid && out_ready) begin
        checks++;
        if (q_main.size() == 0) begin errors++; $display("FAIL bp extra result got %h want none", {cout, s}); end
        else begin
          ev = q_main.pop_front();
          if (32'({cout, s}) !== ev) begin errors++; $display("FAIL bp_order got %h want %h", {cout, s}, ev); end
        end
      end
      @(negedge clk);
      drive(1'b0, 1'b0, '0, '0, 1'b0);
    end
    checks++; if (q_main.size() != 0) begin errors++; $display("FAIL bp_drain left %0d want 0", q_main.size()); end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] ev;
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 1'b0, W'($urandom()), W'($urandom()), 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || s !== '0 || cout !== 1'b0) begin
      errors++; $display("FAIL rstmid_clear got v=%b s=%h c=%b want v=0 s=000 c=0", out_valid, s, cout);
    end
    q_main.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      if (j < 2) drive(1'b1, 1'b1, W'($urandom()), W'($urandom()), 1'b1);
      else drive(1'b0, 1'b0, '0, '0, 1'b0);
      #1;
      if (in_valid && in_ready) q_main.push_back(ref_add(W, SW, K, 32'(a), 32'(b), cin, approx));
      if (out_valid && out_ready) begin
        checks++;
        if (q_main.size() == 0) begin errors++; $display("FAIL rstmid stale result got %h want none", {cout, s}); end
        else begin
          ev = q_main.pop_front();
          if (32'({cout, s}) !== ev) begin errors++; $display("FAIL rstmid got %h want %h", {cout, s}, ev); end
        end
      end
      @(negedge clk);
    end
    checks++; if (q_main.size() != 0) begin errors++; $display("FAIL rstmid_drain left %0d want 0", q_main.size()); end
  endtask

  task automatic test_sweep();
    logic [31:0] ex, ey;
    int nx = 0, ny = 0;
    x_iv = 1; x_ap = 1; x_ci = 1; x_a = 16'h12F8; x_b = 16'h0E0F;
    y_iv = 1; y_ap = 1; y_ci = 1; y_a = 8'hB7; y_b = 8'h4A;
    ex = ref_add(16, 4, 2, 32'(x_a), 32'(x_b), x_ci, x_ap);
    ey = ref_add(8, 2, 0, 32'(y_a), 32'(y_b), y_ci, y_ap);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      x_iv = 0; y_iv = 0;
      #1;
      if (x_ov && nx == 0) begin
        nx = n; checks++;
        if (32'({x_co, x_s}) !== ex) begin errors++; $display("FAIL sweep16_first got %h want %h", {x_co, x_s}, ex); end
      end
      if (y_ov && ny == 0) begin
        ny = n; checks++;
        if (32'({y_co, y_s}) !== ey) begin errors++; $display("FAIL sweep8_first got %h want %h", {y_co, y_s}, ey); end
      end
    end
    checks++; if (nx != 4) begin errors++; $display("FAIL sweep16_latency got %0d want 4", nx); end
    checks++; if (ny != 4) begin errors++; $display("FAIL sweep8_latency got %0d want 4", ny); end
    for (int j = 0; j < 48; j++) begin
      x_iv = (j < 40); x_ap = 1'($urandom_range(0, 1)); x_ci = 1'($urandom_range(0, 1));
      x_a = 16'($urandom()); x_b = 16'($urandom());
      y_iv = (j < 40); y_ap = 1'($urandom_range(0, 1)); y_ci = 1'($urandom_range(0, 1));
      y_a = 8'($urandom()); y_b = 8'($urandom());
      #1;
      if (x_iv && x_ir) q_x.push_back(ref_add(16, 4, 2, 32'(x_a), 32'(x_b), x_ci, x_ap));
      if (y_iv && y_ir) q_y.push_back(ref_add(8, 2, 0, 32'(y_a), 32'(y_b), y_ci, y_ap));
      if (x_ov && x_or) begin
        checks++;
        if (q_x.size() == 0) begin errors++; $display("FAIL sweep16 extra got %h want none", {x_co, x_s}); end
        else begin
          ex = q_x.pop_front();
          if (32'({x_co, x_s}) !== ex) begin errors++; $display("FAIL sweep16 got %h want %h", {x_co, x_s}, ex); end
        end
      end
      if (y_ov && y_or) begin
        checks++;
        if (q_y.size() == 0) begin errors++; $display("FAIL sweep8 extra got %h want none", {y_co, y_s}); end
        else begin
          ey = q_y.pop_front();
          if (32'({y_co, y_s}) !== ey) begin errors++; $display("FAIL sweep8 got %h want %h", {y_co, y_s}, ey); end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (q_x.size() != 0 || q_y.size() != 0) begin
      errors++; $display("FAIL sweep_drain left %0d/%0d want 0/0", q_x.size(), q_y.size());
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_approx();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_seg_adder.md
# pipelined_seg_adder

Parametrised, pipelined segmented adder for the 3x3 Gaussian FIR datapath. It splits a WIDTH-bit addition into SEG_WIDTH-bit carry-lookahead segments and registers one segment per pipeline stage, giving one result per cycle at full clock rate. A per-operation mode bit selects exact addition or approximate addition. In approximate mode the lowest APPROX_SEGS segments are replaced by a sign-extension estimate and no carry chain is computed for them. Valid/ready handshakes on both sides let it sit between the FIR multiply tree and the accumulator/output stage with backpressure.

## Interface
- WIDTH, 12, operand and sum width; must be an integer multiple of SEG_WIDTH
- SEG_WIDTH, 4, bits per lookahead segment; NSEG = WIDTH/SEG_WIDTH (≥2)
- APPROX_SEGS, 1, number of low segments approximated when approx mode is set; 0 ≤ APPROX_SEGS < NSEG

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand word valid
- in_ready  out  1  adder can accept operands this cycle
- approx  in  1  1 = approximate mode for this operation, sampled with operands
- cin  in  1  carry-in (ignored in approx mode when APPROX_SEGS>0)
- a  in  WIDTH  operand A, unsigned
- b  in  WIDTH  operand B, unsigned
- out_valid  out  1  s/cout valid
- out_ready  in  1  downstream accepts result
- s  out  WIDTH  sum
- cout  out  1  carry-out of the top segment

## Operation
- Pipeline has NSEG stages. Stage i computes segment i: bits [(i+1)*SEG_WIDTH-1 : i*SEG_WIDTH].
  - Stage i uses the carry registered by stage i-1; stage 0 uses cin.
  - Segment sum is (a_seg + b_seg + carry) mod 2^SEG_WIDTH; the segment carry-out is bit SEG_WIDTH of that sum.
- Each stage register holds:
  - the valid bit;
  - the approx flag;
  - completed low sum bits;
  - unconsumed upper bits of a and b;
  - the carry into the next segment.
- Exact mode (approx=0): s = (a+b+cin) mod 2^WIDTH; cout = bit WIDTH of a+b+cin.
- Approximate mode (approx=1, APPROX_SEGS=k>0):
  - Let L = k*SEG_WIDTH.
  - s[L-1:0] = all bits equal to a[L-1].
  - Carry into segment k = a[L-1].
  - b[L-1:0] and cin are ignored.
  - Segments k..NSEG-1 are computed exactly.
  - With k=0, approx mode is identical to exact mode.
- Approx stages still occupy their pipeline slot; latency is mode-independent.
- Handshake:
  - Stall = out_valid & ~out_ready. On stall, every stage holds its contents.
  - in_ready = ~stall.
  - A transfer occurs when in_valid & in_ready.
  - Bubbles (stages with valid=0) advance normally and are not compacted.
- s and cout are driven directly from the final stage register. They remain stable while out_valid=1 and out_ready=0.

## Timing
- Reset (async assert): every stage valid bit is cleared. out_valid=0, s=0, cout=0. in_ready=1 once out_valid=0.
- Reset deasserted: the first accept can occur on the first rising edge.
- Latency: an operand accepted at edge t appears with out_valid=1 after edge t+NSEG-1. That is NSEG cycles from the accept cycle to the result cycle (3 cycles for defaults).
- Throughput: one operation per cycle with out_ready held high.
- Ordering: results leave in acceptance order; the approx flag travels with its data.
- Simultaneous events:
  - Accept and output in the same cycle is legal and is the normal case.
  - in_valid during a stall is not accepted; the source must hold a, b, cin and approx.
- Reset mid-operation: all in-flight results are discarded and none appear after reset.
- Overflow: wrap-around mod 2^WIDTH, reported only through cout. There is no saturation.
- No combinational path from a, b or cin to s/cout. in_ready depends combinationally on out_ready and out_valid only.

## Test plan
- Exact carry ripple across all segments (defaults): a=0x7FF, b=0x001, cin=0, approx=0 → after 3 cycles s=0x800, cout=0. Then a=0xFFF, b=0x001 → s=0x000, cout=1.
- Approximate mode: a=0x0A8, b=0x01F, cin=1, approx=1 → s=0x0CF, cout=0. a=0x0A0, b=0x01F, approx=1 → s=0x0B0. Same operands with approx=0 → 0x0C7 and 0x0BF.
- Streaming with mode interleaving: 100 back-to-back random operands with random approx, out_ready=1 → one result per cycle, in order. Each result matches the reference model, and each operand's own approx bit is applied.
- Backpressure: fill the pipeline, drop out_ready for 5 cycles → in_ready=0, and s/cout/out_valid hold steady. Restore out_ready → no loss, no duplication, and order is preserved.
- Reset mid-stream: assert rst asynchronously with 3 operations in flight → out_valid=0, s=0, cout=0 immediately. After deassert, only newly accepted operations emerge.
- Parameter sweep: WIDTH=16, SEG_WIDTH=4, APPROX_SEGS=2, and WIDTH=8, SEG_WIDTH=2, APPROX_SEGS=0 → latency equals NSEG, and random checks match the reference model in both modes.
